// File: rtl/mem_port_scheduler.sv
// ============================================================================
// Module      : mem_port_scheduler
// Description : Round-robin sharing of one memory command/response port among
//               N requesters, one transaction in flight, beat-count checked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_scheduler #(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int LW = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]    req_valid_i,
  output logic [N-1:0]    req_ready_o,
  input  logic [N*AW-1:0] req_addr_i,
  input  logic [N-1:0]    req_we_i,
  input  logic [N*LW-1:0] req_len_i,
  output logic          mem_cmd_valid_o,
  input  logic          mem_cmd_ready_i,
  output logic [AW-1:0] mem_cmd_addr_o,
  output logic          mem_cmd_we_o,
  output logic [LW-1:0] mem_cmd_len_o,
  output logic [IW-1:0] mem_cmd_id_o,
  input  logic          mem_rsp_valid_i,
  input  logic          mem_rsp_last_i,
  output logic [N-1:0]  rsp_valid_o,
  output logic          rsp_last_o,
  output logic [IW-1:0] owner_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;
  logic [LW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [LW-1:0] r_len;
  logic          r_err;

  logic          w_gnt_found;
  logic [IW-1:0] w_gnt_idx;
  logic [N-1:0]  w_req_ready;
  logic          w_cmd_valid;
  logic [N-1:0]  w_rsp_valid;
  logic          w_rsp_last;
  logic          w_err;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Rotating priority search starting at r_ptr, first hit wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(r_ptr) + k) % N;
      if (!w_gnt_found && req_valid_i[j]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_cmd_valid = 1'b0;
    w_rsp_valid = '0;
    w_rsp_last  = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_err = mem_rsp_valid_i;
        if (w_gnt_found) begin
          w_req_ready[w_gnt_idx] = 1'b1;
          w_state_nxt            = S_CMD;
        end
      end
      S_CMD: begin
        w_cmd_valid = 1'b1;
        w_err       = mem_rsp_valid_i;
        if (mem_cmd_ready_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (mem_rsp_valid_i) begin
          // The internal count decides routing and termination; the memory's flag is only checked.
          w_rsp_valid[r_owner] = 1'b1;
          w_rsp_last           = w_cnt_zero;
          w_err                = (mem_rsp_last_i != w_cnt_zero);
          if (w_cnt_zero) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (r_state == S_IDLE && w_gnt_found) begin
        r_owner <= w_gnt_idx;
        r_addr  <= req_addr_i[w_gnt_idx*AW +: AW];
        r_we    <= req_we_i[w_gnt_idx];
        r_len   <= req_len_i[w_gnt_idx*LW +: LW];
      end
      if (r_state == S_CMD && mem_cmd_ready_i) r_cnt <= r_len;
      if (r_state == S_RESP && mem_rsp_valid_i) begin
        if (w_cnt_zero) r_ptr <= IW'((int'(r_owner) + 1) % N);
        else            r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign req_ready_o     = w_req_ready;
  assign mem_cmd_valid_o = w_cmd_valid;
  assign mem_cmd_addr_o  = r_addr;
  assign mem_cmd_we_o    = r_we;
  assign mem_cmd_len_o   = r_len;
  assign mem_cmd_id_o    = r_owner;
  assign rsp_valid_o     = w_rsp_valid;
  assign rsp_last_o      = w_rsp_last;
  assign owner_o         = r_owner;
  assign busy_o          = (r_state != S_IDLE);
  assign err_o           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
// ============================================================================
// Module      : tb_mem_port_scheduler
// Description : Directed self-checking bench for mem_port_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_we_i;
  logic [N*LW-1:0] req_len_i;
  logic          mem_cmd_valid_o;
  logic          mem_cmd_ready_i;
  logic [AW-1:0] mem_cmd_addr_o;
  logic          mem_cmd_we_o;
  logic [LW-1:0] mem_cmd_len_o;
  logic [IW-1:0] mem_cmd_id_o;
  logic          mem_rsp_valid_i;
  logic          mem_rsp_last_i;
  logic [N-1:0]  rsp_valid_o;
  logic          rsp_last_o;
  logic [IW-1:0] owner_o;
  logic          busy_o;
  logic          err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mem_port_scheduler #(.N(N), .AW(AW), .LW(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_len_i(req_len_i),
    .mem_cmd_valid_o(mem_cmd_valid_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_we_o(mem_cmd_we_o),
    .mem_cmd_len_o(mem_cmd_len_o), .mem_cmd_id_o(mem_cmd_id_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_last_i(mem_rsp_last_i),
    .rsp_valid_o(rsp_valid_o), .rsp_last_o(rsp_last_o),
    .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  // Full transaction for requester g: grant, stalled command, len+1 beats, ptr update.
  task automatic do_txn(input int g, input int stall, input bit release_all);
    logic [LW-1:0] len;
    logic [N-1:0]  oh;
    oh  = N'(1) << g;
    len = req_len_i[g*LW +: LW];
    #1;
    tests++;
    if (req_ready_o !== oh) begin
      fails++; $display("FAIL grant: req_ready_o=%b expected %b", req_ready_o, oh);
    end
    @(negedge clk_i);
    mem_cmd_ready_i = 1'b0;
    for (int c = 0; c < stall; c++) begin
      #1;
      tests++;
      if (mem_cmd_valid_o !== 1'b1 || mem_cmd_addr_o !== addr_of(g)) begin
        fails++; $display("FAIL cmd_hold: valid=%b addr=%h expected 1 %h", mem_cmd_valid_o, mem_cmd_addr_o, addr_of(g));
      end
      @(negedge clk_i);
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    tests++;
    if (mem_cmd_valid_o !== 1'b1 || mem_cmd_id_o !== IW'(g) || mem_cmd_we_o !== g[0] ||
        mem_cmd_len_o !== len || mem_cmd_addr_o !== addr_of(g) || req_ready_o !== '0) begin
      fails++; $display("FAIL cmd: valid=%b id=%0d we=%b len=%0d addr=%h expected 1 %0d %b %0d %h",
                        mem_cmd_valid_o, mem_cmd_id_o, mem_cmd_we_o, mem_cmd_len_o, mem_cmd_addr_o,
                        g, g[0], len, addr_of(g));
    end
    @(negedge clk_i);
    mem_cmd_ready_i = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_last_i  = (b == int'(len));
      if (release_all && b == int'(len)) req_valid_i = '0;
      #1;
      tests++;
      if (rsp_valid_o !== oh || rsp_last_o !== (b == int'(len))) begin
        fails++; $display("FAIL beat%0d: rsp_valid_o=%b rsp_last_o=%b expected %b %b",
                          b, rsp_valid_o, rsp_last_o, oh, (b == int'(len)));
      end
      @(negedge clk_i);
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b0 || dut.r_ptr !== IW'((g + 1) % N) || err_o !== 1'b0) begin
      fails++; $display("FAIL done: busy=%b ptr=%0d err=%b expected 0 %0d 0", busy_o, dut.r_ptr, err_o, (g + 1) % N);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_valid_i = '0; req_we_i = 4'b1010; req_len_i = '0;
    mem_cmd_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_last_i = 1'b0;
    for (int i = 0; i < N; i++) req_addr_i[i*AW +: AW] = addr_of(i);
    repeat (2) @(negedge clk_i);
    tests++;
    if (req_ready_o !== '0 || mem_cmd_valid_o !== 1'b0 || mem_cmd_addr_o !== '0 || rsp_valid_o !== '0 ||
        busy_o !== 1'b0 || err_o !== 1'b0 || owner_o !== '0 || dut.r_ptr !== '0) begin
      fails++; $display("FAIL reset: ready=%b cmdv=%b addr=%h rspv=%b busy=%b err=%b owner=%0d",
                        req_ready_o, mem_cmd_valid_o, mem_cmd_addr_o, rsp_valid_o, busy_o, err_o, owner_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_alternate;
    req_valid_i = 4'b0101;
    do_txn(0, 0, 1'b0);
    do_txn(2, 0, 1'b0);
    do_txn(0, 0, 1'b0);
    do_txn(2, 0, 1'b1);
    @(negedge clk_i);
  endtask

  task automatic test_stall_burst;
    req_len_i[1*LW +: LW] = 4'd3;
    req_valid_i = 4'b0010;
    do_txn(1, 5, 1'b1);
    @(negedge clk_i);
  endtask

  task automatic test_last_mismatch;
    req_len_i[0 +: LW] = 4'd2;
    req_valid_i = 4'b0001;
    #1;
    tests++;
    if (req_ready_o !== 4'b0001) begin
      fails++; $display("FAIL err_grant: req_ready_o=%b expected 0001", req_ready_o);
    end
    @(negedge clk_i);
    req_valid_i = '0;
    mem_cmd_ready_i = 1'b1;
    @(negedge clk_i);
    mem_cmd_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_last_i = 1'b0;
    @(negedge clk_i);
    mem_rsp_last_i = 1'b1;
    #1;
    tests++;
    if (rsp_last_o !== 1'b0 || err_o !== 1'b0) begin
      fails++; $display("FAIL beat2: rsp_last_o=%b err_o=%b expected 0 0", rsp_last_o, err_o);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (err_o !== 1'b1 || rsp_valid_o !== 4'b0001 || rsp_last_o !== 1'b1) begin
      fails++; $display("FAIL beat3: err_o=%b rsp_valid_o=%b rsp_last_o=%b expected 1 0001 1", err_o, rsp_valid_o, rsp_last_o);
    end
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0; mem_rsp_last_i = 1'b0;
    #1;
    tests++;
    if (err_o !== 1'b0 || busy_o !== 1'b0 || dut.r_ptr !== 2'd1) begin
      fails++; $display("FAIL err_end: err_o=%b busy=%b ptr=%0d expected 0 0 1", err_o, busy_o, dut.r_ptr);
    end
    @(negedge clk_i);
  endtask

  task automatic test_idle_beat;
    mem_rsp_valid_i = 1'b1;
    #1;
    tests++;
    if (rsp_valid_o !== '0 || rsp_last_o !== 1'b0) begin
      fails++; $display("FAIL idle_drop: rsp_valid_o=%b rsp_last_o=%b expected 0 0", rsp_valid_o, rsp_last_o);
    end
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    #1;
    tests++;
    if (err_o !== 1'b1 || dut.r_ptr !== 2'd1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL idle_err: err_o=%b ptr=%0d busy=%b expected 1 1 0", err_o, dut.r_ptr, busy_o);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (err_o !== 1'b0 || dut.r_ptr !== 2'd1) begin
      fails++; $display("FAIL idle_pulse: err_o=%b ptr=%0d expected 0 1", err_o, dut.r_ptr);
    end
  endtask

  task automatic test_back_to_back;
    int order [8];
    order = '{1, 2, 3, 0, 1, 2, 3, 0};
    req_len_i = '0;
    req_valid_i = 4'b1111;
    for (int t = 0; t < 8; t++) do_txn(order[t], 0, t == 7);
    @(negedge clk_i);
  endtask

  task automatic test_async_reset;
    req_len_i[0 +: LW] = 4'd3;
    req_valid_i = 4'b0001;
    @(negedge clk_i);
    req_valid_i = '0;
    mem_cmd_ready_i = 1'b1;
    @(negedge clk_i);
    mem_cmd_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_last_i = 1'b0;
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b1 || dut.r_cnt !== 4'd2) begin
      fails++; $display("FAIL pre_rst: busy=%b cnt=%0d expected 1 2", busy_o, dut.r_cnt);
    end
    #1 rst_i = 1'b1;
    #1;
    tests++;
    if (busy_o !== 1'b0 || mem_cmd_valid_o !== 1'b0 || mem_cmd_addr_o !== '0 || mem_cmd_len_o !== '0 ||
        rsp_valid_o !== '0 || err_o !== 1'b0 || dut.r_ptr !== '0) begin
      fails++; $display("FAIL async_rst: busy=%b cmdv=%b addr=%h len=%0d rspv=%b err=%b ptr=%0d",
                        busy_o, mem_cmd_valid_o, mem_cmd_addr_o, mem_cmd_len_o, rsp_valid_o, err_o, dut.r_ptr);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL post_rst: err_o=%b busy=%b expected 0 0", err_o, busy_o);
    end
    req_valid_i = 4'b1000;
    do_txn(3, 0, 1'b1);
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset;
    test_alternate;
    test_stall_burst;
    test_last_mismatch;
    test_idle_beat;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
